// File: rtl/clm_mod_p_out_pkg.sv
// Shared types for the redundant-representation AES datapath: lane/state shapes,
// field polynomial and matrix types, and the stage enums of the sequenced blocks.
`define MP_STAGE_BITS 2

package types;

    localparam int d      = 4;
    localparam int lane_w = 8 + d;

    typedef logic [0:lane_w-1]     state_t;
    typedef state_t [0:3][0:3]     state_vec_t;
    typedef logic [0:8]            base_poly_t;
    typedef logic [0:7][0:7]       mm_matrix_t;

    typedef enum logic [1:0] {SB_IDLE, SB_INV, SB_AFFINE} sbox_stages_t;
    typedef enum logic [`MP_STAGE_BITS-1:0] {MP_IDLE, MP_REDUCE, MP_MAP} mod_p_stages_t;

    // GF(2) matrix-vector product, MSB-first indexing on both operands
    function automatic logic [0:7] mm_apply(input mm_matrix_t m, input logic [0:7] v);
        logic [0:7] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            r[i] = ^(m[i] & v);
        end
        return r;
    endfunction

endpackage

// File: rtl/clm_mod_p_out_lane_step.sv
// One polynomial long-division step on a single redundant lane: conditionally
// cancel the leading coefficient with P, then shift towards the MSB.
module clm_lane_step
    import types::*;
(
    input  state_t     lane,
    input  base_poly_t P,
    output state_t     lane_nxt
);

    state_t red_s;

    // conditional subtract of P aligned to the lane MSB, then shift left
    always_comb begin
        red_s = lane;
        if (lane[0]) begin
            red_s[0:8] = lane[0:8] ^ P;
        end else begin
            red_s = lane;
        end
        lane_nxt = {red_s[1:lane_w-1], 1'b0};
    end

endmodule

// File: rtl/clm_mod_p_out.sv
// Reduces the 16 redundant state lanes modulo P in d sequential steps, then maps
// each remainder through Linv into the standard-basis ciphertext.
module clm_mod_p_out
    import types::*;
#(
    parameter int d = types::d
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          drdy_i,
    input  state_vec_t    in,
    input  base_poly_t    P,
    input  mm_matrix_t    Linv,
    output logic [127:0]  ciphertext,
    output logic          drdy_o,
    output logic          busy
);

    localparam int cnt_w = $clog2(d + 1);

    mod_p_stages_t    state_r;
    mod_p_stages_t    next_state_s;
    logic [cnt_w-1:0] cnt_r;
    state_vec_t       lanes_r;
    state_vec_t       step_s;
    base_poly_t       poly_r;
    logic [127:0]     ct_s;
    logic             load_s;
    logic             step_en_s;
    logic             map_s;

    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        for (genvar gj = 0; gj < 4; gj++) begin : g_col
            clm_lane_step u_step (
                .lane     (lanes_r[gi][gj]),
                .P        (poly_r),
                .lane_nxt (step_s[gi][gj])
            );
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MP_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; leaves REDUCE once the d-th step is being applied
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            MP_IDLE:   next_state_s = drdy_i ? MP_REDUCE : MP_IDLE;
            MP_REDUCE: next_state_s = (cnt_r == cnt_w'(d - 1)) ? MP_MAP : MP_REDUCE;
            MP_MAP:    next_state_s = MP_IDLE;
            default:   next_state_s = MP_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        load_s    = 1'b0;
        step_en_s = 1'b0;
        map_s     = 1'b0;
        case (state_r)
            MP_IDLE:   load_s    = drdy_i;
            MP_REDUCE: step_en_s = 1'b1;
            MP_MAP:    map_s     = 1'b1;
            default: begin
                load_s    = 1'b0;
                step_en_s = 1'b0;
                map_s     = 1'b0;
            end
        endcase
    end

    // output isomorphism applied to the remainder held in each lane's top byte
    always_comb begin
        ct_s = '0;
        for (int k = 0; k < 16; k++) begin
            ct_s[8*k +: 8] = mm_apply(Linv, lanes_r[k/4][k%4][0:7]);
        end
    end

    // datapath: operand capture, reduction steps, result and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= '0;
            lanes_r    <= '0;
            poly_r     <= '0;
            ciphertext <= 128'h0;
            drdy_o     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            drdy_o <= map_s;
            // busy also covers the drdy_o cycle that follows MAP
            busy   <= (next_state_s != MP_IDLE) || map_s;
            if (load_s) begin
                lanes_r <= in;
                poly_r  <= P;
                cnt_r   <= '0;
            end else if (step_en_s) begin
                lanes_r <= step_s;
                cnt_r   <= cnt_r + cnt_w'(1);
            end
            if (map_s) begin
                ciphertext <= ct_s;
            end
        end
    end

endmodule

// File: tb/tb_clm_mod_p_out.sv
// Directed and randomized checks of clm_mod_p_out against a long-division
// reference model of remainder-then-matrix mapping.
module tb_clm_mod_p_out;
    import types::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         drdy_i;
    state_vec_t   in_s;
    base_poly_t   p_s;
    mm_matrix_t   linv_s;
    logic [127:0] ciphertext;
    logic         drdy_o;
    logic         busy;

    int checks = 0;
    int errors = 0;

    clm_mod_p_out dut (
        .clk        (clk),
        .rst        (rst),
        .drdy_i     (drdy_i),
        .in         (in_s),
        .P          (p_s),
        .Linv       (linv_s),
        .ciphertext (ciphertext),
        .drdy_o     (drdy_o),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // remainder by polynomial long division on integers, then matrix product
    function automatic logic [127:0] model(input state_vec_t v, input base_poly_t p,
                                           input mm_matrix_t m);
        logic [127:0] res;
        int x, pv, rem, ob;
        logic bit_v;
        res = '0;
        pv  = int'(p);
        for (int k = 0; k < 16; k++) begin
            x = int'(v[k/4][k%4]);
            for (int b = 11; b >= 8; b--) begin
                if (x[b]) x = x ^ (pv << (b - 8));
            end
            rem = x & 255;
            ob  = 0;
            for (int i = 0; i < 8; i++) begin
                bit_v = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    if (m[i][j] && rem[7-j]) bit_v = ~bit_v;
                end
                if (bit_v) ob = ob | (1 << (7 - i));
            end
            res[8*k +: 8] = ob[7:0];
        end
        return res;
    endfunction

    function automatic state_vec_t rand_vec();
        state_vec_t v;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                v[i][j] = 12'($urandom);
        return v;
    endfunction

    function automatic state_vec_t fill_vec(input logic [11:0] val);
        state_vec_t v;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                v[i][j] = val;
        return v;
    endfunction

    task automatic run_op(input string tag, input state_vec_t v, input base_poly_t p,
                          input mm_matrix_t m, input logic [127:0] exp);
        int lat;
        @(negedge clk);
        in_s = v; p_s = p; linv_s = m; drdy_i = 1'b1;
        @(negedge clk);
        drdy_i = 1'b0;
        chk({tag, "_busy_load"}, 128'(busy), 128'(1));
        in_s = rand_vec();
        p_s  = {1'b1, 8'($urandom)};
        lat  = 1;
        while (drdy_o !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(6));
        chk({tag, "_ct"}, ciphertext, exp);
        chk({tag, "_busy_done"}, 128'(busy), 128'(1));
        @(negedge clk);
        chk({tag, "_drdy_pulse"}, 128'(drdy_o), 128'(0));
        chk({tag, "_busy_idle"}, 128'(busy), 128'(0));
        chk({tag, "_ct_hold"}, ciphertext, exp);
    endtask

    initial begin
        mm_matrix_t ident, brev, mr;
        state_vec_t va, vb;
        base_poly_t pa, pr;
        logic [127:0] exp_a, exp_b;
        int lat, pulses, first;

        for (int i = 0; i < 8; i++) begin
            ident[i] = 8'h00; ident[i][i] = 1'b1;
            brev[i]  = 8'h00; brev[i][7-i] = 1'b1;
        end
        rst = 1'b1; drdy_i = 1'b0; in_s = '0; p_s = 9'h11B; linv_s = ident;
        repeat (3) @(negedge clk);
        chk("reset_drdy_o", 128'(drdy_o), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        chk("reset_ct", ciphertext, 128'h0);
        rst = 1'b0;

        run_op("all_0ab", fill_vec(12'h0AB), 9'h11B, ident, {16{8'hAB}});

        va = fill_vec(12'h001);
        va[0][0] = 12'h100; va[0][1] = 12'h11B; va[0][2] = 12'h236;
        run_op("mixed", va, 9'h11B, ident, {{13{8'h01}}, 8'h00, 8'h00, 8'h1B});

        run_op("bitrev", fill_vec(12'h001), 9'h11B, brev, {16{8'h80}});

        for (int t = 0; t < 6; t++) begin
            va = rand_vec();
            pr = {1'b1, 8'($urandom)};
            for (int i = 0; i < 8; i++) mr[i] = 8'($urandom);
            run_op("random", va, pr, mr, model(va, pr, mr));
        end

        // second strobe while busy must be ignored
        va = rand_vec(); vb = rand_vec(); pa = 9'h11B;
        exp_a = model(va, pa, ident);
        @(negedge clk);
        in_s = va; p_s = pa; linv_s = ident; drdy_i = 1'b1;
        @(negedge clk);
        drdy_i = 1'b0;
        @(negedge clk);
        in_s = vb; p_s = 9'h163; drdy_i = 1'b1;
        @(negedge clk);
        drdy_i = 1'b0;
        pulses = 0; first = 0;
        for (int c = 3; c <= 20; c++) begin
            if (drdy_o === 1'b1) begin
                pulses++;
                if (first == 0) first = c;
            end
            @(negedge clk);
        end
        chk("ignore_pulses", 128'(pulses), 128'(1));
        chk("ignore_latency", 128'(first), 128'(6));
        chk("ignore_ct", ciphertext, exp_a);

        // reset in flight aborts the operation
        @(negedge clk);
        in_s = rand_vec(); drdy_i = 1'b1;
        @(negedge clk);
        drdy_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (drdy_o === 1'b1) pulses++;
            @(negedge clk);
        end
        chk("abort_pulses", 128'(pulses), 128'(0));
        chk("abort_ct", ciphertext, 128'h0);
        chk("abort_busy", 128'(busy), 128'(0));
        va = rand_vec();
        run_op("after_abort", va, 9'h11B, ident, model(va, 9'h11B, ident));

        // reset wins over a simultaneous strobe
        @(negedge clk);
        rst = 1'b1; drdy_i = 1'b1;
        @(negedge clk);
        rst = 1'b0; drdy_i = 1'b0;
        chk("rst_prio_busy", 128'(busy), 128'(0));
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (drdy_o === 1'b1) pulses++;
        end
        chk("rst_prio_pulses", 128'(pulses), 128'(0));

        // back-to-back: new strobe in the drdy_o cycle
        va = rand_vec(); vb = rand_vec();
        for (int i = 0; i < 8; i++) mr[i] = 8'($urandom);
        exp_a = model(va, 9'h11B, mr);
        exp_b = model(vb, 9'h11D, mr);
        @(negedge clk);
        in_s = va; p_s = 9'h11B; linv_s = mr; drdy_i = 1'b1;
        @(negedge clk);
        drdy_i = 1'b0;
        lat = 1;
        while (drdy_o !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_latency", 128'(lat), 128'(6));
        chk("b2b_first_ct", ciphertext, exp_a);
        in_s = vb; p_s = 9'h11D; drdy_i = 1'b1;
        @(negedge clk);
        drdy_i = 1'b0;
        chk("b2b_busy", 128'(busy), 128'(1));
        lat = 1;
        while (drdy_o !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_second_latency", 128'(lat), 128'(6));
        chk("b2b_second_ct", ciphertext, exp_b);
        @(negedge clk);
        chk("b2b_end_busy", 128'(busy), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
